// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator: format codes and RV32/RV64 base opcodes.
// FMT_Z is only produced when IMM_GEN_CSR_EN is defined, but its code stays reserved in every build.
package imm_gen_pkg;

    localparam int FMT_W = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classification and I/S/B/U/J immediate build, sign-extended to XLEN.
// IMM_GEN_CSR_EN adds the CSR-immediate (Z) format for SYSTEM opcodes.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output fmt_e            fmt_o,
    output logic [XLEN-1:0] imm_o
);

    // Every format fits in 32 signed bits, so widen once at the end.
    logic [31:0] imm32;

    always_comb begin
        fmt_o = FMT_NONE;
        imm32 = '0;
        case (instr_i[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                fmt_o = FMT_I;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm32 = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            end
`ifdef IMM_GEN_CSR_EN
            OPC_SYSTEM: begin
                if (instr_i[14]) begin
                    // CSRR*I: uimm lives in the rs1 field and is zero-extended
                    fmt_o = FMT_Z;
                    imm32 = {27'b0, instr_i[19:15]};
                end else begin
                    fmt_o = FMT_I;
                    imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
`endif
            default: begin
                fmt_o = FMT_NONE;
                imm32 = '0;
            end
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: 1-cycle latency, main register plus skid entry for full throughput.
// in_ready is registered (= no skid entry held); flush clears both valid bits, data fields hold.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        fmt_e             fmt;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } entry_t;

    fmt_e            dec_fmt;
    logic [XLEN-1:0] dec_imm;
    entry_t          new_ent;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;

    logic in_xfer;
    logic drain;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i (in_instr),
        .fmt_o   (dec_fmt),
        .imm_o   (dec_imm)
    );

    assign new_ent = '{fmt: dec_fmt, imm: dec_imm, tag: in_tag};
    assign in_xfer = in_valid & in_ready & ~flush;
    assign drain   = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            if (skid_vld_q) begin
                // Older skid entry goes first to keep results in order
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = in_xfer;
                if (in_xfer) begin
                    skid_d = new_ent;
                end
            end else begin
                main_vld_d = in_xfer;
                if (in_xfer) begin
                    main_d = new_ent;
                end
            end
        end else if (in_xfer) begin
            skid_d     = new_ent;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready  = ~skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_imm   = main_q.imm;
    assign out_fmt   = main_q.fmt;
    assign out_tag   = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe at XLEN=64: decode vector table, backpressure, flush and async reset.
module tb_imm_gen_pipe;

    localparam int XLEN  = 64;
    localparam int TAG_W = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_fmt;
    logic [TAG_W-1:0] out_tag;

    logic [2:0]      drv_fmt;
    logic [XLEN-1:0] drv_imm;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    bit rnd_on;

    typedef struct {
        logic [2:0]       fmt;
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0]     instr;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[$];

    imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_tag   (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on consumed output.
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: tag 0x%0h appeared with no pending entry", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("sb_fmt", 64'(out_fmt), 64'(e.fmt));
                    check("sb_imm", out_imm, e.imm);
                    check("sb_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back('{drv_fmt, drv_imm, in_tag});
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [TAG_W-1:0] tag,
                        input logic [2:0] f, input logic [XLEN-1:0] imm);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        drv_fmt  = f;
        drv_imm  = imm;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag 0x%0h not accepted within 50 cycles", tag);
        end
    endtask

    task automatic drain_sb(input string name);
        out_ready = 1'b1;
        for (int n = 0; n < 60 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int t0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_instr = '0;
        in_tag   = '0;
        drv_fmt  = '0;
        drv_imm  = '0;
        rnd_on   = 1'b0;

        vecs.push_back('{32'hFFDFF06F, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC});
        vecs.push_back('{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{32'h123450B7, 3'd4, 64'h0000_0000_1234_5000});
        vecs.push_back('{32'hFE20AC23, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8});
        vecs.push_back('{32'h00000863, 3'd3, 64'h0000_0000_0000_0010});
        vecs.push_back('{32'hFE000FE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{32'h80000017, 3'd4, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{32'h7FF00003, 3'd1, 64'h0000_0000_0000_07FF});
        vecs.push_back('{32'h80000067, 3'd1, 64'hFFFF_FFFF_FFFF_F800});
        vecs.push_back('{32'h002081B3, 3'd0, 64'h0});
        vecs.push_back('{32'h0080006F, 3'd5, 64'h0000_0000_0000_0008});
`ifdef IMM_GEN_CSR_EN
        vecs.push_back('{32'h300FD073, 3'd6, 64'h0000_0000_0000_001F});
        vecs.push_back('{32'h30001073, 3'd1, 64'h0000_0000_0000_0300});
`else
        vecs.push_back('{32'h300FD073, 3'd0, 64'h0});
        vecs.push_back('{32'h30001073, 3'd0, 64'h0});
`endif

        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pass 1: full throughput, one accepted per cycle
        out_ready = 1'b1;
        t0 = cycle;
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].instr, 32'h1000 + 32'(i) * 4, vecs[i].fmt, vecs[i].imm);
        end
        check("throughput_cycles", 64'(cycle - t0), 64'(vecs.size()));
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_tag", 64'(out_tag), 64'(32'h1000 + 32'(vecs.size() - 1) * 4));
        @(posedge clk);
        #1;
        drain_sb("drain_pass1");

        // Pass 2: random consumer stalls exercise the skid path
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < vecs.size(); i++) begin
                    send(vecs[i].instr, 32'h2000 + 32'(i), vecs[i].fmt, vecs[i].imm);
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    if (rnd_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain_sb("drain_pass2");

        // Backpressure: A in main, B in skid, C held until space frees
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'hFFF00093, 32'hA, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h123450B7, 32'hB, 3'd4, 64'h0000_0000_1234_5000);
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_main_tag", 64'(out_tag), 64'hA);
        @(posedge clk);
        #1;
        fork
            send(32'hFFDFF06F, 32'hC, 3'd5, 64'hFFFF_FFFF_FFFF_FFFC);
            begin
                @(negedge clk);
                check("bp_c_held", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_order_a_vld", 64'(out_valid), 64'd1);
                check("bp_order_a", 64'(out_tag), 64'hA);
                @(negedge clk);
                check("bp_order_b_vld", 64'(out_valid), 64'd1);
                check("bp_order_b", 64'(out_tag), 64'hB);
                @(negedge clk);
                check("bp_order_c_vld", 64'(out_valid), 64'd1);
                check("bp_order_c", 64'(out_tag), 64'hC);
            end
        join
        drain_sb("drain_bp");

        // Flush with both entries full and an input presented
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h7FF00003, 32'hD, 3'd1, 64'h7FF);
        send(32'h00000863, 32'hE, 3'd3, 64'h10);
        in_valid = 1'b1;
        in_instr = 32'hFFDFF06F;
        in_tag   = 32'hF;
        flush    = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_keeps_data", 64'(out_tag), 64'hD);
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("flush_no_ghost", 64'(out_valid), 64'd0);
        end

        // Async reset mid-stream with both entries full
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'hFFF00093, 32'h51, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h80000017, 32'h52, 3'd4, 64'hFFFF_FFFF_8000_0000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_imm", out_imm, 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'hFE20AC23, 32'h60, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8);
        drain_sb("drain_post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
